// File: rtl/syn_cfg_chain_ctrl.sv
// -----------------------------------------------------------------------------
// syn_cfg_chain_ctrl
//
// Sequences the synapse configuration daisy chain. Host words arrive over a
// valid/ready handshake. Each word is presented on cfg_data_out, and then one
// rising edge of the slow chain clock cfg_data_clk shifts it into the chain
// head. After CHAIN_LEN = NUM_SYN*STAGES_PER_SYN words the first word
// accepted sits in the tail stage, which is the last synapse's output stage.
//
// Optional feature (macro CFG_READBACK_EN):
//   read_start performs a non-destructive readback. The chain tail is fed
//   back into the head for CHAIN_LEN shifts. Each tail word is reported on
//   rd_data/rd_valid, so the words come out in the original host load order.
//   Without the macro, read_start is ignored and rd_data/rd_valid are 0.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   load_start   pulse, begin a load pass (IDLE only; wins over read_start)
//   read_start   pulse, begin a readback pass (feature only, IDLE only)
//   host_data    word to shift in
//   host_valid   host_data valid
//   host_ready   controller accepts host_data this cycle (WAIT_WORD)
//   cfg_data_clk chain shift clock (registered, 50% duty within a word)
//   cfg_data_out word driven into the chain head
//   cfg_data_ret word from the chain tail
//   rd_data      readback word
//   rd_valid     rd_data valid, one-cycle pulse
//   busy         pass in progress
//   done         one-cycle pulse at the end of a pass
// -----------------------------------------------------------------------------
module syn_cfg_chain_ctrl #(
  parameter int WORD_LENGTH    = 16,
  parameter int NUM_SYN        = 8,
  parameter int STAGES_PER_SYN = 4,
  parameter int CLK_HALF       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   read_start,
  input  logic [WORD_LENGTH-1:0] host_data,
  input  logic                   host_valid,
  output logic                   host_ready,
  output logic                   cfg_data_clk,
  output logic [WORD_LENGTH-1:0] cfg_data_out,
  input  logic [WORD_LENGTH-1:0] cfg_data_ret,
  output logic [WORD_LENGTH-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int CHAIN_LEN = NUM_SYN * STAGES_PER_SYN;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int HALF_W    = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WORD,
    PHASE_LO,
    PHASE_HI,
    FINISH
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       word_cnt_reg, word_cnt_next;
  logic [HALF_W-1:0]      half_cnt_reg, half_cnt_next;
  logic                   read_mode_reg, read_mode_next;
  logic [WORD_LENGTH-1:0] data_out_reg, data_out_next;
  logic                   cfg_clk_reg;
  logic                   sample_ret;
  logic                   half_last;
  logic                   word_last;

  assign half_last = (half_cnt_reg == HALF_W'(CLK_HALF - 1));
  // The increment on PHASE_HI exit reaches CHAIN_LEN exactly when this is set.
  assign word_last = (word_cnt_reg == CNT_W'(CHAIN_LEN - 1));

  always_comb begin
    state_next     = state_reg;
    word_cnt_next  = word_cnt_reg;
    half_cnt_next  = half_cnt_reg;
    read_mode_next = read_mode_reg;
    sample_ret     = 1'b0;

    case (state_reg)
      IDLE: begin
        half_cnt_next = '0;
        if (load_start) begin
          state_next     = WAIT_WORD;
          word_cnt_next  = '0;
          read_mode_next = 1'b0;
`ifdef CFG_READBACK_EN
        end else if (read_start) begin
          state_next     = PHASE_LO;
          word_cnt_next  = '0;
          read_mode_next = 1'b1;
          sample_ret     = 1'b1;
`endif
        end
      end

      WAIT_WORD: begin
        // host_ready is 1 in this state, so valid alone completes a transfer.
        if (host_valid) begin
          state_next    = PHASE_LO;
          half_cnt_next = '0;
        end
      end

      PHASE_LO: begin
        if (half_last) begin
          state_next    = PHASE_HI;
          half_cnt_next = '0;
        end else begin
          half_cnt_next = half_cnt_reg + HALF_W'(1);
        end
      end

      PHASE_HI: begin
        if (half_last) begin
          half_cnt_next = '0;
          word_cnt_next = word_cnt_reg + CNT_W'(1);
          if (word_last) begin
            state_next = FINISH;
          end else if (read_mode_reg) begin
            state_next = PHASE_LO;
            sample_ret = 1'b1;
          end else begin
            state_next = WAIT_WORD;
          end
        end else begin
          half_cnt_next = half_cnt_reg + HALF_W'(1);
        end
      end

      FINISH: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Head data: a host word on acceptance, or the recirculated tail word during
  // readback. The tail only moves on a rising chain edge, so a sample taken on
  // entry to PHASE_LO is the same word seen in the last PHASE_LO cycle. It also
  // gives the head a full CLK_HALF of setup before the next rising edge.
  always_comb begin
    data_out_next = data_out_reg;
    if (state_reg == WAIT_WORD && host_valid) begin
      data_out_next = host_data;
    end else if (sample_ret) begin
      data_out_next = cfg_data_ret;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      word_cnt_reg  <= '0;
      half_cnt_reg  <= '0;
      read_mode_reg <= 1'b0;
      data_out_reg  <= '0;
      cfg_clk_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      word_cnt_reg  <= word_cnt_next;
      half_cnt_reg  <= half_cnt_next;
      read_mode_reg <= read_mode_next;
      data_out_reg  <= data_out_next;
      // Registered from next state: the rising edge coincides with PHASE_HI entry.
      cfg_clk_reg   <= (state_next == PHASE_HI);
    end
  end

  assign host_ready   = (state_reg == WAIT_WORD);
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == FINISH);
  assign cfg_data_clk = cfg_clk_reg;
  assign cfg_data_out = data_out_reg;

`ifdef CFG_READBACK_EN
  logic [WORD_LENGTH-1:0] rd_data_reg;
  logic                   rd_valid_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= sample_ret;
      if (sample_ret) begin
        rd_data_reg <= cfg_data_ret;
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
`else
  // Readback inputs have no function in this build.
  logic unused_readback;
  assign unused_readback = ^{read_start, sample_ret};
  assign rd_data  = '0;
  assign rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_syn_cfg_chain_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for syn_cfg_chain_ctrl.
// The main instance uses NUM_SYN=2 and CLK_HALF=2, and a behavioural chain is
// clocked by cfg_data_clk. A second instance (NUM_SYN=1, CLK_HALF=1) covers the
// fastest chain clock. Pass expectations are queued when a pass is started.
// A monitor checks them when done or rd_valid appears.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_syn_cfg_chain_ctrl;

  localparam int WL  = 16;
  localparam int NS  = 2;
  localparam int SPS = 4;
  localparam int CH  = 2;
  localparam int CL  = NS * SPS;

  typedef struct {
    int            start_cyc;
    int            start_edges;
    int            exp_latency;
    logic [CL*WL-1:0] img;
  } pass_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_start = 1'b0;
  logic          read_start = 1'b0;
  logic [WL-1:0] host_data = '0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic          cfg_data_clk;
  logic [WL-1:0] cfg_data_out;
  logic [WL-1:0] cfg_data_ret;
  logic [WL-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;

  // small instance
  logic          ls1 = 1'b0;
  logic          hr1, clk1, rv1, busy1, done1;
  logic [WL-1:0] out1, rd1;
  logic [WL-1:0] hd1 = 16'h00A5;
  logic [WL-1:0] ret1 = '0;
  logic          hv1 = 1'b1;
  logic          rs1 = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int edge_cnt = 0;

  pass_t         pass_q[$];
  logic [WL-1:0] rd_q[$];
  logic [WL-1:0] stim_words [CL];
  logic [WL-1:0] model_words [CL];
  logic [WL-1:0] chain [CL];
  pass_t         mon_p;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  syn_cfg_chain_ctrl #(.WORD_LENGTH(WL), .NUM_SYN(NS), .STAGES_PER_SYN(SPS), .CLK_HALF(CH)) u_dut (
    .clk(clk), .reset(reset), .load_start(load_start), .read_start(read_start),
    .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
    .cfg_data_clk(cfg_data_clk), .cfg_data_out(cfg_data_out), .cfg_data_ret(cfg_data_ret),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done)
  );

  syn_cfg_chain_ctrl #(.WORD_LENGTH(WL), .NUM_SYN(1), .STAGES_PER_SYN(SPS), .CLK_HALF(1)) u_small (
    .clk(clk), .reset(reset), .load_start(ls1), .read_start(rs1),
    .host_data(hd1), .host_valid(hv1), .host_ready(hr1),
    .cfg_data_clk(clk1), .cfg_data_out(out1), .cfg_data_ret(ret1),
    .rd_data(rd1), .rd_valid(rv1), .busy(busy1), .done(done1)
  );

  // Behavioural chain: head at index 0, tail at CL-1, shifts on the rising edge.
  always @(posedge cfg_data_clk) begin
    for (int i = CL - 1; i > 0; i--) chain[i] <= chain[i-1];
    chain[0] <= cfg_data_out;
    edge_cnt <= edge_cnt + 1;
  end
  assign cfg_data_ret = chain[CL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event occurred with no expectation or bound expired", name);
  endtask

  // The first word loaded ends at the tail, and the last word ends at the head.
  function automatic logic [CL*WL-1:0] image_of(input logic [WL-1:0] w [CL]);
    logic [CL*WL-1:0] r;
    r = '0;
    for (int k = 0; k < CL; k++) r[(CL-1-k)*WL +: WL] = w[k];
    return r;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (rd_valid) begin
        if (rd_q.size() == 0) bad("rd_unexpected");
        else check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
      end
      if (done) begin
        if (pass_q.size() == 0) bad("done_unexpected");
        else begin
          logic [CL*WL-1:0] act;
          mon_p = pass_q.pop_front();
          check("done_latency", 32'(cyc - mon_p.start_cyc), 32'(mon_p.exp_latency));
          check("edge_count", 32'(edge_cnt - mon_p.start_edges), 32'(CL));
          for (int i = 0; i < CL; i++) act[i*WL +: WL] = chain[i];
          tests++;
          if (act !== mon_p.img) begin
            fails++;
            $display("FAIL chain_image: got 0x%0h expected 0x%0h", act, mon_p.img);
          end
          $display("[TB] pass done at cycle %0d latency %0d", cyc, cyc - mon_p.start_cyc);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!host_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!host_ready) bad("host_ready_timeout");
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) bad("busy_timeout");
  endtask

  task automatic do_load(input int stall_idx, input int stall_len, input int glitch_idx,
                         input int abort_idx, input bit both_start);
    pass_t p;
    @(posedge clk); #1;
    load_start = 1'b1;
    if (both_start) read_start = 1'b1;
    if (abort_idx < 0) begin
      p.start_cyc   = cyc + 1;
      p.start_edges = edge_cnt;
      p.exp_latency = CL * (2 * CH + 1) + ((stall_idx >= 0) ? stall_len : 0);
      p.img         = image_of(stim_words);
      pass_q.push_back(p);
      model_words = stim_words;
    end
    @(posedge clk); #1;
    load_start = 1'b0;
    read_start = 1'b0;
    for (int k = 0; k < CL; k++) begin
      if (k == glitch_idx) begin
        load_start = 1'b1;
        read_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        read_start = 1'b0;
      end
      if (k == stall_idx) begin
        host_valid = 1'b0;
        @(negedge clk);
        wait_ready();
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check("stall_cfg_clk", 32'(cfg_data_clk), 32'd0);
          check("stall_ready", 32'(host_ready), 32'd1);
        end
      end
      host_data  = stim_words[k];
      host_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;
      $display("[TB] word %0d = 0x%04h accepted at cycle %0d", k, stim_words[k], cyc);
      if (k + 1 == abort_idx) begin
        host_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_cfg_out", 32'(cfg_data_out), 32'd0);
        check("abort_cfg_clk", 32'(cfg_data_clk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(host_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rd", 32'({rd_valid, rd_data}), 32'd0);
        return;
      end
    end
    host_valid = 1'b0;
  endtask

`ifdef CFG_READBACK_EN
  task automatic do_read();
    pass_t p;
    @(posedge clk); #1;
    read_start    = 1'b1;
    p.start_cyc   = cyc + 1;
    p.start_edges = edge_cnt;
    p.exp_latency = CL * 2 * CH;
    p.img         = image_of(model_words);
    pass_q.push_back(p);
    for (int k = 0; k < CL; k++) rd_q.push_back(model_words[k]);
    @(posedge clk); #1;
    read_start = 1'b0;
  endtask
`endif

  task automatic random_words();
    for (int k = 0; k < CL; k++) stim_words[k] = WL'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rise, rises, high_cyc, lat;
    bit seen_busy;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(host_ready), 32'd0);
    check("rst_cfg_clk", 32'(cfg_data_clk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_cfg_out", 32'(cfg_data_out), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: ordered load 1..8
    for (int k = 0; k < CL; k++) stim_words[k] = WL'(k + 1);
    do_load(-1, 0, -1, -1, 1'b0);
    wait_idle();
    check("syn0_erev", 32'(chain[0]), 32'h8);
    check("syn0_weight", 32'(chain[1]), 32'h7);
    check("syn0_tau", 32'(chain[2]), 32'h6);
    check("syn1_erev", 32'(chain[4]), 32'h4);
    check("cfg_out_hold", 32'(cfg_data_out), 32'h8);

`ifdef CFG_READBACK_EN
    // 5: two readbacks return load order
    do_read();
    wait_idle();
    do_read();
    wait_idle();
`else
    @(posedge clk); #1;
    read_start = 1'b1;
    @(posedge clk); #1;
    read_start = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || rd_valid || cfg_data_clk) seen_busy = 1'b1;
    end
    check("read_ignored", 32'(seen_busy), 32'd0);
`endif

    // 2: stall before word 3, same contents
    do_load(2, 10, -1, -1, 1'b0);
    wait_idle();

    // 3: both starts together in IDLE, then start pulses mid-pass
    random_words();
    do_load(-1, 0, 3, -1, 1'b1);
    wait_idle();

    // 4: reset after word 5, then a fresh load
    random_words();
    do_load(-1, 0, -1, 5, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", 32'(busy), 32'd0);
    random_words();
    do_load(-1, 0, -1, -1, 1'b0);
    wait_idle();

    // random passes with random stalls
    for (int r = 0; r < 3; r++) begin
      random_words();
      do_load(int'($urandom_range(0, CL - 1)), int'($urandom_range(1, 12)), -1, -1, 1'b0);
      wait_idle();
`ifdef CFG_READBACK_EN
      do_read();
      wait_idle();
`endif
    end

    // 6: NUM_SYN=1, CLK_HALF=1 instance
    @(posedge clk); #1;
    ls1 = 1'b1;
    first_rise = cyc + 1;
    @(posedge clk); #1;
    ls1 = 1'b0;
    rises = 0;
    high_cyc = 0;
    lat = -1;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      logic prev;
      prev = clk1;
      @(negedge clk);
      if (clk1) high_cyc++;
      if (clk1 && !prev) rises++;
      if (done1) lat = cyc - first_rise;
    end
    if (lat < 0) bad("small_done_timeout");
    else check("small_latency", 32'(lat), 32'd12);
    check("small_edges", 32'(rises), 32'd4);
    check("small_high_cycles", 32'(high_cyc), 32'd4);
    $display("[TB] small pass latency %0d edges %0d", lat, rises);

    repeat (5) @(negedge clk);
    check("pass_q_empty", 32'(pass_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
